spm_stream_mult: RTL and testbench

Parametrised signed serial-parallel multiplier with a handshake front end and a serial product stream. It is the successor to the fixed-width spm carry-save-adder array. WIDTH is configurable, and operands are accepted in parallel through a valid/ready port. The product leaves LSB-first under backpressure. It sits between the operand-issue logic and any bit-serial consumer, and can optionally also deliver the full product in parallel.

---
 rtl/spm_pkg.sv | 17 +
 rtl/spm_csa_cell.sv | 45 ++++
 rtl/spm_stream_mult.sv | 181 ++++++++++++++++++
 tb/tb_spm_stream_mult.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and constants for the spm_stream_mult serial-parallel multiplier.
package spm_pkg;

    localparam int SPM_MIN_WIDTH = 2;
    localparam int SPM_MAX_WIDTH = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } spm_state_e;

    // Bit count cnt needs to index all 2*WIDTH product bits.
    function automatic int spm_cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell of the spm chain: a partial-product bit plus the sum of
// the next-higher cell plus this cell's own carry, held in a sum and a carry flop.
module spm_csa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic s_in,
    input  logic clr,
    input  logic en,
    output logic sum
);

    logic carry_r;
    logic s_eff_s;
    logic c_eff_s;
    logic hsum1;
    logic hcar1_s;
    logic hsum2;
    logic hcar2_s;

    // clr forces the stored state to zero so the accept cycle only loads a.
    always_comb begin
        s_eff_s = s_in & ~clr;
        c_eff_s = carry_r & ~clr;
        hsum1   = a ^ s_eff_s;
        hcar1_s = a & s_eff_s;
        hsum2   = hsum1 ^ c_eff_s;
        hcar2_s = hsum1 & c_eff_s;
    end

    // Sum/carry state; frozen while en is low (consumer stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= 1'b0;
            carry_r <= 1'b0;
        end else if (en) begin
            sum     <= hsum2;
            carry_r <= hcar1_s | hcar2_s;
        end else begin
            sum     <= sum;
            carry_r <= carry_r;
        end
    end

endmodule

// File: rtl/spm_stream_mult.sv
// Signed serial-parallel multiplier streaming the 2*WIDTH-bit product LSB-first.
// Optional parallel product output is enabled with the SPM_PARALLEL_OUT_EN macro.
module spm_stream_mult
    import spm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               p_valid,
    input  logic               p_ready,
    output logic               p_bit,
    output logic               p_last,
    output logic               busy
`ifdef SPM_PARALLEL_OUT_EN
    ,
    output logic [2*WIDTH-1:0] p_par,
    output logic               p_par_valid
`endif
);

    localparam int             CW   = spm_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(2 * WIDTH - 1);

    if (WIDTH < SPM_MIN_WIDTH || WIDTH > SPM_MAX_WIDTH) begin : g_bad_width
        $error("spm_stream_mult: WIDTH out of range");
    end

    spm_state_e       state_r;
    spm_state_e       state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             accept_s;
    logic             step_s;
    logic             done_s;
    logic             in_ready_r;
    logic             p_valid_r;
    logic             p_last_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             msb_sum_r;
    logic             msb_seen_r;
    logic [WIDTH-1:0] pp_s;
    logic [WIDTH-1:0] chain_s;

    // Next-state and handshake decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                    cnt_s    = {CW{1'b0}};
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (p_ready) begin
                    step_s = 1'b1;
                    if (cnt_r == LAST) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and flop-driven status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            p_valid_r  <= 1'b0;
            p_last_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            in_ready_r <= (state_s == ST_IDLE);
            p_valid_r  <= (state_s == ST_RUN);
            p_last_r   <= (state_s == ST_RUN) && (cnt_s == LAST);
        end
    end

    // The accept cycle already performs step 0 straight from the operand inputs,
    // so bit 0 is in the cell-0 sum flop one cycle after the accept edge.
    always_comb begin
        if (accept_s) begin
            pp_s = x & {WIDTH{y[0]}};
        end else begin
            pp_s = x_r & {WIDTH{y_r[0]}};
        end
    end

    // Operand registers; y shifts arithmetically so the upper steps see its sign.
    // The MSB cell serially negates the x[WIDTH-1] partial-product stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r        <= {WIDTH{1'b0}};
            y_r        <= {WIDTH{1'b0}};
            msb_sum_r  <= 1'b0;
            msb_seen_r <= 1'b0;
        end else if (accept_s) begin
            x_r        <= x;
            y_r        <= {y[WIDTH-1], y[WIDTH-1:1]};
            msb_sum_r  <= pp_s[WIDTH-1];
            msb_seen_r <= pp_s[WIDTH-1];
        end else if (step_s) begin
            x_r        <= x_r;
            y_r        <= {y_r[WIDTH-1], y_r[WIDTH-1:1]};
            msb_sum_r  <= pp_s[WIDTH-1] ^ msb_seen_r;
            msb_seen_r <= pp_s[WIDTH-1] | msb_seen_r;
        end else begin
            x_r        <= x_r;
            y_r        <= y_r;
            msb_sum_r  <= msb_sum_r;
            msb_seen_r <= msb_seen_r;
        end
    end

    assign chain_s[WIDTH-1] = msb_sum_r;

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_cell
        spm_csa_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .a    (pp_s[i]),
            .s_in (chain_s[i+1]),
            .clr  (accept_s),
            .en   (accept_s | step_s),
            .sum  (chain_s[i])
        );
    end

    assign in_ready = in_ready_r;
    assign p_valid  = p_valid_r;
    assign busy     = p_valid_r;
    assign p_last   = p_last_r;
    assign p_bit    = chain_s[0];

`ifdef SPM_PARALLEL_OUT_EN
    logic [2*WIDTH-1:0] col_r;
    logic               par_valid_r;

    // Collector: each taken bit enters at the MSB, so bit 0 ends at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r       <= {(2*WIDTH){1'b0}};
            par_valid_r <= 1'b0;
        end else if (step_s) begin
            col_r       <= {chain_s[0], col_r[2*WIDTH-1:1]};
            par_valid_r <= done_s;
        end else begin
            col_r       <= col_r;
            par_valid_r <= 1'b0;
        end
    end

    assign p_par       = col_r;
    assign p_par_valid = par_valid_r;
`endif

endmodule

// File: tb/tb_spm_stream_mult.sv
// Randomized self-checking bench for spm_stream_mult against an arithmetic product model.
module tb_spm_stream_mult;

`ifdef SPM_PARALLEL_OUT_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          p_valid;
    logic          p_ready;
    logic          p_bit;
    logic          p_last;
    logic          busy;
`ifdef SPM_PARALLEL_OUT_EN
    logic [PW-1:0] p_par;
    logic          p_par_valid;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    spm_stream_mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_bit    (p_bit),
        .p_last   (p_last),
        .busy     (busy)
`ifdef SPM_PARALLEL_OUT_EN
        ,
        .p_par       (p_par),
        .p_par_valid (p_par_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        longint pr;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        pr = pa * pb;
        return pr[PW-1:0];
    endfunction

    // mode: 0 = p_ready held high, 1 = random stalls, 2 = pattern 1,0,0 repeating.
    // abort_at >= 0 pulses rst after checking that bit; linger checks p_par hold.
    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input int mode,
                          input bit hold, input int abort_at, input bit linger,
                          output int acc_cyc);
        logic [PW-1:0] want;
        int  k;
        int  stalls;
        int  guard;
        int  phase;
        bit  pr;
        want  = ref_prod(xv, yv);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_wait", 64'(in_ready), 64'd1);
        x = xv;
        y = yv;
        in_valid = 1'b1;
        p_ready  = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        k = 0; stalls = 0; phase = 0; guard = 0;
        while (k < PW && guard < 8 * PW) begin
            if (hold) begin
                x = W'($urandom);
                y = W'($urandom);
            end
            check_eq("p_valid", 64'(p_valid), 64'd1);
            check_eq($sformatf("bit%0d", k), 64'(p_bit), 64'(want[k]));
            check_eq("p_last", 64'(p_last), 64'(k == PW - 1));
            check_eq("in_ready_run", 64'(in_ready), 64'd0);
            if (k == abort_at) begin
                rst = 1'b1;
                p_ready = 1'b1;
                @(negedge clk);
                check_eq("abort_p_valid", 64'(p_valid), 64'd0);
                check_eq("abort_p_last", 64'(p_last), 64'd0);
                check_eq("abort_busy", 64'(busy), 64'd0);
                rst = 1'b0;
                @(negedge clk);
                check_eq("abort_in_ready", 64'(in_ready), 64'd1);
                check_eq("abort_p_valid2", 64'(p_valid), 64'd0);
                return;
            end
            case (mode)
                0:       pr = 1'b1;
                1:       pr = ($urandom_range(0, 2) != 0);
                2:       pr = ((phase % 3) == 0);
                default: pr = 1'b1;
            endcase
            phase++;
            p_ready = pr;
            @(negedge clk);
            guard++;
            if (pr) k++;
            else stalls++;
        end
        in_valid = 1'b0;
        p_ready  = 1'b1;
        check_eq("handshakes", 64'(k), 64'(PW));
        check_eq("end_p_valid", 64'(p_valid), 64'd0);
        check_eq("end_p_last", 64'(p_last), 64'd0);
        check_eq("end_busy", 64'(busy), 64'd0);
        check_eq("end_in_ready", 64'(in_ready), 64'd1);
        check_eq("latency", 64'(cyc - acc_cyc), 64'(PW + stalls));
`ifdef SPM_PARALLEL_OUT_EN
        check_eq("p_par_valid", 64'(p_par_valid), 64'd1);
        check_eq("p_par", 64'(p_par), 64'(want));
        if (linger) begin
            @(negedge clk);
            check_eq("p_par_valid_drop", 64'(p_par_valid), 64'd0);
            check_eq("p_par_hold", 64'(p_par), 64'(want));
        end
`else
        if (linger) @(negedge clk);
`endif
    endtask

    initial begin
        logic [W-1:0] most_neg;
        logic [W-1:0] most_pos;
        int           t0;
        int           t1;
        most_neg = {1'b1, {(W-1){1'b0}}};
        most_pos = {1'b0, {(W-1){1'b1}}};
        rst = 1'b1; in_valid = 1'b0; p_ready = 1'b1;
        x = '0; y = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_p_valid", 64'(p_valid), 64'd0);
        check_eq("rst_p_bit", 64'(p_bit), 64'd0);
        check_eq("rst_p_last", 64'(p_last), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);

        run_op(W'(3), W'(5), 0, 1'b0, -1, 1'b1, t0);
        run_op({W{1'b1}}, {W{1'b1}}, 0, 1'b0, -1, 1'b1, t0);
        run_op(most_neg, most_neg, 0, 1'b0, -1, 1'b1, t0);
        run_op(most_neg, most_pos, 0, 1'b0, -1, 1'b1, t0);
        run_op(W'(8'h5A), W'(8'h33), 2, 1'b0, -1, 1'b1, t0);
        run_op(W'(8'h5A), W'(8'h33), 0, 1'b0, 6, 1'b1, t0);
        run_op(W'(7), W'(-9), 0, 1'b0, -1, 1'b1, t0);
        run_op(W'(-300), W'(1234), 1, 1'b1, -1, 1'b1, t0);

        run_op(W'(-300), W'(1234), 0, 1'b0, -1, 1'b0, t0);
        run_op(W'(77), W'(-5), 0, 1'b0, -1, 1'b0, t1);
        check_eq("issue_interval", 64'(t1 - t0), 64'(PW + 1));

`ifdef SPM_PARALLEL_OUT_EN
        for (int i = 0; i < 1000; i++) begin
`else
        for (int i = 0; i < 300; i++) begin
`endif
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), t0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
